// File: rtl/sliding_window_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sliding_window_pkg
//  Description : Shared types and default sizing for the sliding window
//                controller. Holds the controller state encoding and the
//                default block width and occupancy counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package sliding_window_pkg;

  // Default number of words loaded per block and width of the occupancy count.
  localparam int DEFAULT_LANES       = 8;
  localparam int DEFAULT_COUNT_WIDTH = 4;

  // Width of the optional underrun event counter.
  localparam int UNDERRUN_WIDTH      = 16;

  // EMPTY: no words held, DRAIN: two or more words held, LAST: one word held.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    DRAIN = 2'd1,
    LAST  = 2'd2
  } sw_state_e;

endpackage : sliding_window_pkg
`default_nettype wire

// File: rtl/sliding_window_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : sliding_window_controller_if
//  Description : Handshake bundle between the sliding window controller and
//                its producer / consumer / datapath.
//                master : producer+consumer side (drives fill_valid,
//                         consume_req, observes everything else)
//                slave  : controller side
//                Signals: fill_valid, fill_ready, in_write, consume_req,
//                         consume_ack, out_read, count[COUNT_WIDTH], empty,
//                         underrun_count[16] when
//                         SLIDING_WINDOW_CONTROLLER_UNDERRUN_COUNT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sliding_window_controller_if #(
  parameter int COUNT_WIDTH = sliding_window_pkg::DEFAULT_COUNT_WIDTH
);

  logic                   fill_valid;
  logic                   fill_ready;
  logic                   in_write;
  logic                   consume_req;
  logic                   consume_ack;
  logic                   out_read;
  logic [COUNT_WIDTH-1:0] count;
  logic                   empty;
`ifdef SLIDING_WINDOW_CONTROLLER_UNDERRUN_COUNT_EN
  logic [sliding_window_pkg::UNDERRUN_WIDTH-1:0] underrun_count;
`endif

  modport master (
    output fill_valid,
    output consume_req,
    input  fill_ready,
    input  in_write,
    input  consume_ack,
    input  out_read,
    input  count,
`ifdef SLIDING_WINDOW_CONTROLLER_UNDERRUN_COUNT_EN
    input  underrun_count,
`endif
    input  empty
  );

  modport slave (
    input  fill_valid,
    input  consume_req,
    output fill_ready,
    output in_write,
    output consume_ack,
    output out_read,
    output count,
`ifdef SLIDING_WINDOW_CONTROLLER_UNDERRUN_COUNT_EN
    output underrun_count,
`endif
    output empty
  );

endinterface : sliding_window_controller_if
`default_nettype wire

// File: rtl/sliding_window_controller_occupancy_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sliding_window_occupancy_counter
//  Description : Occupancy counter for the sliding window. A load sets the
//                count to LANES (and wins over a simultaneous decrement, so a
//                read of the last word plus a new block lands on LANES); a
//                decrement removes one word and never wraps below zero.
//                Ports: clock, reset_n (async, active-low), load, dec,
//                       count[COUNT_WIDTH] (registered).
//  Revision    : 1.0 - initial release
// ============================================================================
module sliding_window_occupancy_counter #(
  parameter int LANES       = 8,
  parameter int COUNT_WIDTH = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   load,
  input  logic                   dec,
  output logic [COUNT_WIDTH-1:0] count
);

  localparam logic [COUNT_WIDTH-1:0] c_full_count = COUNT_WIDTH'(LANES);
  localparam logic [COUNT_WIDTH-1:0] c_one        = COUNT_WIDTH'(1);

  logic [COUNT_WIDTH-1:0] r_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= c_full_count;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - c_one;
    end
  end

  assign count = r_count;

endmodule : sliding_window_occupancy_counter
`default_nettype wire

// File: rtl/sliding_window_controller.sv
`default_nettype none
// ============================================================================
//  Module      : sliding_window_controller
//  Description : Control for a LANES-word sliding window. Accepts a full block
//                from a producer when the window is empty (or is handing out
//                its last word this cycle) and hands words to a consumer one
//                per cycle. A refill coinciding with the last read gives a
//                gap-free stream.
//                Ports: clock, reset_n (async, active-low),
//                       bus (sliding_window_controller_if.slave).
//                Optional: SLIDING_WINDOW_CONTROLLER_UNDERRUN_COUNT_EN adds a
//                saturating 16-bit count of requests made while empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module sliding_window_controller
  import sliding_window_pkg::*;
#(
  parameter int LANES       = DEFAULT_LANES,
  parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
  input  logic                        clock,
  input  logic                        reset_n,
  sliding_window_controller_if.slave  bus
);

  // With a single lane a fresh block is already the last word.
  localparam sw_state_e              c_load_state = (LANES == 1) ? LAST : DRAIN;
  localparam logic [COUNT_WIDTH-1:0] c_count_two  = COUNT_WIDTH'(2);

  sw_state_e              r_state;
  sw_state_e              w_state_next;
  logic                   w_fill_ready;
  logic                   w_consume_ack;
  logic [COUNT_WIDTH-1:0] w_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Handshakes are gated with reset_n so nothing is accepted or delivered
  // while the block is held in reset, even though EMPTY would accept a fill.
  always_comb begin
    w_state_next  = r_state;
    w_fill_ready  = 1'b0;
    w_consume_ack = 1'b0;
    if (reset_n) begin
      case (r_state)
        EMPTY: begin
          w_fill_ready = bus.fill_valid;
          if (w_fill_ready) begin
            w_state_next = c_load_state;
          end
        end
        DRAIN: begin
          w_consume_ack = bus.consume_req;
          if (w_consume_ack && (w_count == c_count_two)) begin
            w_state_next = LAST;
          end
        end
        LAST: begin
          w_consume_ack = bus.consume_req;
          w_fill_ready  = bus.fill_valid & bus.consume_req;
          if (w_fill_ready) begin
            w_state_next = c_load_state;
          end else if (w_consume_ack) begin
            w_state_next = EMPTY;
          end
        end
        default: begin
          w_state_next = EMPTY;
        end
      endcase
    end
  end

  sliding_window_occupancy_counter #(
    .LANES       (LANES),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_occupancy_counter (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (w_fill_ready),
    .dec     (w_consume_ack),
    .count   (w_count)
  );

  assign bus.fill_ready  = w_fill_ready;
  assign bus.in_write    = w_fill_ready;
  assign bus.consume_ack = w_consume_ack;
  assign bus.out_read    = w_consume_ack;
  assign bus.count       = w_count;
  assign bus.empty       = (r_state == EMPTY);

`ifdef SLIDING_WINDOW_CONTROLLER_UNDERRUN_COUNT_EN
  localparam logic [UNDERRUN_WIDTH-1:0] c_underrun_one = UNDERRUN_WIDTH'(1);

  logic [UNDERRUN_WIDTH-1:0] r_underrun_count;

  // Saturating: once all ones, further underruns are not recorded.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_underrun_count <= '0;
    end else if (bus.consume_req && (r_state == EMPTY) && (r_underrun_count != '1)) begin
      r_underrun_count <= r_underrun_count + c_underrun_one;
    end
  end

  assign bus.underrun_count = r_underrun_count;
`endif

endmodule : sliding_window_controller
`default_nettype wire

// File: tb/tb_sliding_window_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sliding_window_controller
//  Description : Self-checking bench for sliding_window_controller (LANES=8).
//                A reference occupancy model predicts each cycle's handshakes
//                and next count; predictions are queued when stimulus is
//                driven and compared by a monitor when the DUT responds.
//                Optional: SLIDING_WINDOW_CONTROLLER_UNDERRUN_COUNT_EN enables
//                the underrun counter scenario.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sliding_window_controller;
  import sliding_window_pkg::*;

  localparam int LANES = 8;
  localparam int CW    = 4;

  typedef struct {
    logic          fill;
    logic          ack;
    logic [CW-1:0] next_count;
  } exp_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  sliding_window_controller_if #(.COUNT_WIDTH(CW)) bus ();

  sliding_window_controller #(
    .LANES       (LANES),
    .COUNT_WIDTH (CW)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  exp_t sb_q[$];
  int   n_vec   = 0;
  int   n_err   = 0;
  int   m_count = 0;

  // Reference model: occupancy only, independent of the DUT's state encoding.
  task automatic drive(input logic fv, input logic cr);
    exp_t e;
    @(negedge clock);
    bus.fill_valid  = fv;
    bus.consume_req = cr;
    e.ack  = cr && (m_count != 0);
    e.fill = fv && ((m_count == 0) || ((m_count == 1) && cr));
    if (e.fill)     m_count = LANES;
    else if (e.ack) m_count = m_count - 1;
    e.next_count = CW'(m_count);
    sb_q.push_back(e);
  endtask

  task automatic settle();
    @(posedge clock);
    #3;
  endtask

  // Monitor: handshakes mid-cycle after inputs settle, count/empty after edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        n_vec++;
        if (bus.fill_ready !== e.fill) begin
          n_err++;
          $display("FAIL fill_ready: got %b want %b @%0t", bus.fill_ready, e.fill, $time);
        end
        n_vec++;
        if (bus.in_write !== e.fill) begin
          n_err++;
          $display("FAIL in_write: got %b want %b @%0t", bus.in_write, e.fill, $time);
        end
        n_vec++;
        if (bus.consume_ack !== e.ack) begin
          n_err++;
          $display("FAIL consume_ack: got %b want %b @%0t", bus.consume_ack, e.ack, $time);
        end
        n_vec++;
        if (bus.out_read !== e.ack) begin
          n_err++;
          $display("FAIL out_read: got %b want %b @%0t", bus.out_read, e.ack, $time);
        end
        @(posedge clock);
        #1;
        n_vec++;
        if (bus.count !== e.next_count) begin
          n_err++;
          $display("FAIL count: got %0d want %0d @%0t", bus.count, e.next_count, $time);
        end
        n_vec++;
        if (bus.empty !== (e.next_count == '0)) begin
          n_err++;
          $display("FAIL empty: got %b want %b @%0t", bus.empty, (e.next_count == '0), $time);
        end
      end
    end
  end

  task automatic test_reset();
    bus.fill_valid  = 1'b1;
    bus.consume_req = 1'b1;
    reset_n         = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    n_vec++;
    if (bus.count !== '0) begin
      n_err++; $display("FAIL reset_count: got %0d want 0", bus.count);
    end
    n_vec++;
    if (bus.empty !== 1'b1) begin
      n_err++; $display("FAIL reset_empty: got %b want 1", bus.empty);
    end
    n_vec++;
    if (bus.fill_ready !== 1'b0 || bus.in_write !== 1'b0) begin
      n_err++; $display("FAIL reset_fill: got %b/%b want 0/0", bus.fill_ready, bus.in_write);
    end
    n_vec++;
    if (bus.consume_ack !== 1'b0 || bus.out_read !== 1'b0) begin
      n_err++; $display("FAIL reset_ack: got %b/%b want 0/0", bus.consume_ack, bus.out_read);
    end
    @(negedge clock);
    bus.fill_valid  = 1'b0;
    bus.consume_req = 1'b0;
    reset_n         = 1'b1;
    m_count         = 0;
  endtask

  task automatic test_load();
    drive(1'b1, 1'b0);
    settle();
    n_vec++;
    if (dut.r_state !== DRAIN) begin
      n_err++; $display("FAIL load_state: got %0d want %0d", dut.r_state, DRAIN);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < LANES; i++) drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);  // request with nothing left
    drive(1'b0, 1'b0);
    settle();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b0);
    for (int i = 0; i < LANES - 1; i++) drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);  // last word read and refill in one cycle
    drive(1'b0, 1'b1);
    settle();
    n_vec++;
    if (dut.r_state !== DRAIN) begin
      n_err++; $display("FAIL b2b_state: got %0d want %0d", dut.r_state, DRAIN);
    end
  endtask

  task automatic test_blocked_fill();
    // Model is at 7 here; pull it down to 5, then offer a block.
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1);
    // Drain fully, then load from empty with a simultaneous request.
    for (int i = 0; i < LANES + 1; i++) drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b0);
    settle();
  endtask

  task automatic test_reset_mid_drain();
    while (m_count > 3) drive(1'b0, 1'b1);
    settle();
    @(negedge clock);
    bus.fill_valid  = 1'b1;
    bus.consume_req = 1'b1;
    reset_n         = 1'b0;
    #1;
    n_vec++;
    if (bus.count !== '0 || bus.empty !== 1'b1) begin
      n_err++; $display("FAIL midreset_count: got %0d/%b want 0/1", bus.count, bus.empty);
    end
    n_vec++;
    if (bus.fill_ready !== 1'b0 || bus.consume_ack !== 1'b0 ||
        bus.in_write !== 1'b0 || bus.out_read !== 1'b0) begin
      n_err++; $display("FAIL midreset_outputs: got %b%b%b%b want 0000",
                        bus.fill_ready, bus.in_write, bus.consume_ack, bus.out_read);
    end
    m_count = 0;
    @(negedge clock);
    bus.fill_valid  = 1'b0;
    bus.consume_req = 1'b0;
    reset_n         = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b1);
    settle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drive(1'b0, 1'b0);
    settle();
  endtask

`ifdef SLIDING_WINDOW_CONTROLLER_UNDERRUN_COUNT_EN
  task automatic test_underrun();
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    m_count = 0;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    settle();
    n_vec++;
    if (bus.underrun_count !== 16'd3) begin
      n_err++; $display("FAIL underrun_count: got %0d want 3", bus.underrun_count);
    end
    @(negedge clock);
    force dut.r_underrun_count = 16'hFFFF;
    @(negedge clock);
    release dut.r_underrun_count;
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    settle();
    n_vec++;
    if (bus.underrun_count !== 16'hFFFF) begin
      n_err++; $display("FAIL underrun_saturate: got %h want ffff", bus.underrun_count);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    bus.fill_valid  = 1'b0;
    bus.consume_req = 1'b0;
    test_reset();
    test_load();
    test_drain();
    test_back_to_back();
    test_blocked_fill();
    test_reset_mid_drain();
    test_random();
`ifdef SLIDING_WINDOW_CONTROLLER_UNDERRUN_COUNT_EN
    test_underrun();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_sliding_window_controller
`default_nettype wire

// File: doc/sliding_window_controller.md
SLIDING_WINDOW_CONTROLLER -- requirements
Module: sliding_window_controller

Interface
REQ-001 Parameter LANES, default 8, words per window block loaded in parallel.
REQ-002 Parameter COUNT_WIDTH, default 4, width of occupancy count (holds 0..LANES).
REQ-003 clock  input  1  sole clock, all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 fill_valid  input  1  producer offers one full LANES-word block.
REQ-006 fill_ready  output  1  block accepted this cycle.
REQ-007 in_write  output  1  load strobe to window datapath; identical to fill_ready.
REQ-008 consume_req  input  1  consumer requests one word.
REQ-009 consume_ack  output  1  word delivered this cycle.
REQ-010 out_read  output  1  shift strobe to window datapath; identical to consume_ack.
REQ-011 count  output  COUNT_WIDTH  valid words remaining in window, registered.
REQ-012 empty  output  1  high when count == 0, registered.

Function
REQ-013 FSM states SHALL be EMPTY (count 0), DRAIN (count >= 2), LAST (count 1); state registered.
REQ-014 consume_ack = consume_req AND state != EMPTY, combinational, zero-cycle latency.
REQ-015 fill_ready = fill_valid AND (state == EMPTY OR (state == LAST AND consume_req)).
REQ-016 Block load SHALL set count to LANES next cycle, replacing window contents.
REQ-017 LAST with consume_req and fill accepted: old last word read and new block loaded same cycle; next count = LANES, state DRAIN, no bubble.
REQ-018 LAST with consume_req, no fill: next count 0, state EMPTY.
REQ-019 DRAIN with consume_ack: count decrements by 1; DRAIN -> LAST when count becomes 1.
REQ-020 fill_valid in DRAIN, or in LAST without consume_req: fill_ready low, producer holds block.
REQ-021 EMPTY with consume_req: consume_ack low, count stays 0.
REQ-022 EMPTY with fill_valid and consume_req same cycle: load only, no ack; count = LANES.
REQ-023 count SHALL never exceed LANES nor wrap below 0.
REQ-024 LANES == 1: DRAIN unreachable; load enters LAST directly.

Reset
REQ-025 reset_n low SHALL asynchronously force state EMPTY, count 0, empty 1; fill_ready, in_write, consume_ack and out_read low while reset_n is low.
REQ-026 Reset mid-drain discards remaining words; first cycle after release behaves as EMPTY.

Configuration
REQ-027 Macro SLIDING_WINDOW_CONTROLLER_UNDERRUN_COUNT_EN defined: output underrun_count, 16 bits, increments each cycle consume_req is high in EMPTY, saturates at 0xFFFF, resets to 0.
REQ-028 Macro undefined: underrun_count port and logic absent; all other behaviour identical.

Structure
REQ-029 Package sliding_window_pkg SHALL hold the state enum (EMPTY, DRAIN, LAST) and the default LANES and COUNT_WIDTH constants.
REQ-030 Sub-module sliding_window_occupancy_counter SHALL implement load-to-LANES / decrement / hold counter with async reset; FSM and handshakes stay in the top.

Verification
REQ-031 Reset, then fill_valid 1 cycle -> fill_ready and in_write 1 that cycle; next cycle count 8, state DRAIN, empty 0.
REQ-032 From count 8, consume_req held 8 cycles -> 8 acks, count 7..0; 9th request -> no ack, empty 1.
REQ-033 Drain to count 1, then consume_req with fill_valid same cycle -> both acks high; next count 8, no empty cycle.
REQ-034 fill_valid asserted at count 5 -> fill_ready low until count 1 plus consume_req, or count 0.
REQ-035 reset_n pulsed low at count 3 mid-drain -> count 0, outputs low immediately; no ack after release until a load.
REQ-036 Macro defined: 3 cycles consume_req while EMPTY -> underrun_count 3; forced to 0xFFFF, one more -> stays 0xFFFF.
